// File: rtl/dual_is_pkg.sv
// Shared types for the dual-issue core: architectural widths and the writeback entry.
package dual_is_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// 2-write / 1-read in-order FIFO of writeback entries; exposes per-entry valid+rd
// so the owner can build a pending-destination mask.
module wb_fifo
  import dual_is_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          i_push_cnt,
  input  wb_entry_t                           i_push_a,
  input  wb_entry_t                           i_push_b,
  input  logic                                i_pop,
  output logic [CNT_W-1:0]                    o_count,
  output wb_entry_t                           o_head,
  output logic [DEPTH-1:0]                    o_ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    o_ent_rd
);
  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Storage is not reset: only entries between rptr and rptr+count are ever observed.
  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) r_mem[r_wptr] <= i_push_a;
    if (i_push_cnt == 2'd2) r_mem[r_wptr + PTR_W'(1)] <= i_push_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(i_push_cnt);
      r_rptr  <= r_rptr + PTR_W'(i_pop);
      r_count <= r_count + CNT_W'(i_push_cnt) - CNT_W'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] w_off;
    assign w_off        = PTR_W'(i) - r_rptr;
    assign o_ent_vld[i] = ({1'b0, w_off} < r_count);
    assign o_ent_rd[i]  = r_mem[i].rd;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: accepts up to two results per cycle in program order and
// retires one per cycle into the register-file write port.
module wb_arbiter
  import dual_is_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        reg_write,
  output logic [31:0] pend_mask
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]                 w_count;
  wb_entry_t                        w_head;
  wb_entry_t                        w_e0;
  wb_entry_t                        w_e1;
  wb_entry_t                        w_push_a;
  logic [DEPTH-1:0]                 w_ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_ent_rd;
  logic                             w_st0;
  logic                             w_st1;
  logic                             w_pop;
  logic [1:0]                       w_push_cnt;
  logic [NUM_REGS-1:0]              w_pend;

  logic                             r_reg_write;
  logic [REG_ADDR_W-1:0]            r_write_reg;
  logic [XLEN-1:0]                  r_write_data;

  // Readys look only at occupancy, so there is no valid->ready path.
  assign wb0_ready = (w_count <= CNT_W'(DEPTH - 1));
  assign wb1_ready = (w_count <= CNT_W'(DEPTH - 2));

  // x0 results handshake normally but are never stored.
  assign w_st0 = wb0_valid & wb0_ready & (wb0_rd != 5'd0);
  assign w_st1 = wb1_valid & wb1_ready & (wb1_rd != 5'd0);
  assign w_e0  = '{rd: wb0_rd, data: wb0_data};
  assign w_e1  = '{rd: wb1_rd, data: wb1_data};

  // Compact stored results so the older one always lands at wptr.
  assign w_push_cnt = {1'b0, w_st0} + {1'b0, w_st1};
  assign w_push_a   = w_st0 ? w_e0 : w_e1;
  assign w_pop      = (w_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push_cnt(w_push_cnt),
    .i_push_a  (w_push_a),
    .i_push_b  (w_e1),
    .i_pop     (w_pop),
    .o_count   (w_count),
    .o_head    (w_head),
    .o_ent_vld (w_ent_vld),
    .o_ent_rd  (w_ent_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_pop;
      if (w_pop) begin
        r_write_reg  <= w_head.rd;
        r_write_data <= w_head.data;
      end
    end
  end

  always_comb begin
    w_pend = r_reg_write ? rd_onehot(r_write_reg) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i]) w_pend = w_pend | rd_onehot(w_ent_rd[i]);
    end
  end

  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign pend_mask  = w_pend;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the dual-issue core. It collects completed results from both issue pipes, up to two per cycle, and queues them in order in a small FIFO. It drains one result per cycle into the single write port of `register_file` (`write_reg`, `write_data`, `reg_write`). It also exports a pending-write mask so issue logic can stall on unretired destinations.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `wb0_valid`, in, 1: pipe 0 result valid. Pipe 0 holds the older instruction.
- `wb0_rd`, in, 5: pipe 0 destination register.
- `wb0_data`, in, 32: pipe 0 result.
- `wb0_ready`, out, 1: pipe 0 result accepted at the edge when `valid & ready`.
- `wb1_valid`, in, 1: pipe 1 result valid. Pipe 1 holds the younger instruction.
- `wb1_rd`, in, 5: pipe 1 destination register.
- `wb1_data`, in, 32: pipe 1 result.
- `wb1_ready`, out, 1: pipe 1 accept, same rule as pipe 0.
- `write_reg`, out, 5: register file write address; registered.
- `write_data`, out, 32: register file write data; registered.
- `reg_write`, out, 1: register file write enable; registered; high for exactly one cycle per entry.
- `pend_mask`, out, 32: bit r is high while any write to r is queued or on the output stage.

## Operation

- `count` is the occupancy at the start of the cycle.
  - `wb0_ready = (count <= DEPTH-1)`.
  - `wb1_ready = (count <= DEPTH-2)`.
  - Neither ready depends on a valid, so there is no combinational valid→ready path.
- **Enqueue order:** pipe 0 is enqueued before pipe 1. Pipe 1 may be accepted alone.
- **Producer stall:** a producer whose result is not accepted holds `valid`, `rd` and `data` stable until it is accepted.
- **x0 results:** `rd == 0` with `valid & ready` completes the handshake but is not stored. It uses no slot and never sets a `pend_mask` bit.
- **Dequeue:** every cycle with `count > 0`, the head is popped into the output register at the edge.
  - `reg_write <= 1`, `write_reg <= head.rd`, `write_data <= head.data`.
  - With `count == 0`: `reg_write <= 0`. `write_reg` and `write_data` hold their previous values.
- **Count update:** `count_next = count + enq_cnt - deq`, where `enq_cnt` is 0..2 and `deq` is 0 or 1. Simultaneous enqueue and dequeue is legal at any occupancy.
- **Pointers:** read and write pointers have width `$clog2(DEPTH)` and wrap modulo `DEPTH`.
  - With two enqueues, pipe 0 goes to `wptr` and pipe 1 goes to `wptr+1`, mod `DEPTH`.
- **Ordering:** results are written in strict program order. When both pipes target the same rd in one cycle, both are written, and pipe 1's value lands last.
- **pend_mask:** combinational OR of the one-hot rd decode of all valid FIFO entries, plus `write_reg` when `reg_write = 1`.
- **Reset:** `count`, `rptr`, `wptr`, `reg_write`, `write_reg` and `write_data` all go to 0.
  - Consequently `pend_mask = 0` and both readys = 1.
  - Reset mid-operation discards all queued entries; none of them is ever written.

## Timing

- A result accepted at edge N is presented on `write_*`/`reg_write` after edge N+1 (minimum latency of one edge). It is held for one cycle.
- The `pend_mask` bit is set after edge N and cleared after the edge that ends its `reg_write` cycle, unless another entry holds the same rd.
- Sustained throughput is 1 write/cycle; burst input is 2/cycle until `wb1_ready` drops.
- Outputs are driven straight from flops; only `pend_mask` and the readys are combinational, and only from internal state.

## Structure

- **Shared package `dual_is_pkg`:**
  - `XLEN = 32`.
  - `REG_ADDR_W = 5`.
  - `NUM_REGS = 32`.
  - `wb_entry_t`, a packed struct of `rd` and `data`.
- **Sub-module `wb_fifo`:** 2-write/1-read FIFO parameterised by `DEPTH`. It exposes `count`, the head entry, and the per-entry valid + rd vector used for `pend_mask`.
- **`wb_arbiter` itself:** handshake logic, x0 filtering, the output register, and the mask reduction.

## Test plan

All scenarios use `DEPTH = 4`.

1. **Reset:** assert `rst` for 2 cycles → `reg_write = 0`, `write_reg = 0`, `write_data = 0`, `pend_mask = 0`, `wb0_ready = wb1_ready = 1`.
2. **Single write:** pipe 0 `rd = 5`, `data = 0xDEADBEEF` accepted at edge 1.
   - After edge 2: `reg_write = 1`, `write_reg = 5`, `write_data = 0xDEADBEEF` for exactly one cycle.
   - `pend_mask[5] = 1` after edge 1, then 0 after edge 3.
3. **Dual same rd:** pipe 0 (`rd = 10`, `0xCAFEBABE`) and pipe 1 (`rd = 10`, `0x12345678`) in one cycle → writes on two consecutive cycles, `0xCAFEBABE` then `0x12345678`.
4. **x0 filter:** pipe 0 `rd = 0`, `data = 0x12345678` → handshake completes, `reg_write` stays 0, `pend_mask = 0`, count unchanged.
5. **Backpressure:** dual results on two consecutive cycles (`rd` 1,2 then 3,4) → count = 3.
   - `wb1_ready = 0`, `wb0_ready = 1`.
   - A held pipe 1 result (`rd = 6`) is accepted only once count ≤ 2.
   - The write sequence is 1, 2, 3, 4, then the pipe 1 result (`rd = 6`).
6. **Reset mid-operation:** assert `rst` with count = 3 → next cycle `reg_write = 0`, `pend_mask = 0`; none of the queued rds is written afterwards.
